// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared TLB geometry, entry field offsets, fill-FSM states and entry builder.
package cpu_defs;
  localparam int TLB_ENTRIES = 8;
  localparam int TLB_ENTRY_W = 27;
  localparam int TLB_VPN_HI  = 26;
  localparam int TLB_VPN_LO  = 7;
  localparam int TLB_PFN_HI  = 6;
  localparam int TLB_PFN_LO  = 4;
  localparam int TLB_V       = 3;
  localparam int TLB_P       = 2;
  localparam int TLB_RW      = 1;
  localparam int TLB_PCD     = 0;
  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_WRITE, S_FLUSH} tlb_state_t;
  typedef struct packed {
    logic [19:0] vpn;
    logic [2:0]  pfn;
    logic        present;
    logic        rw;
    logic        pcd;
  } tlb_req_t;
  function automatic logic [TLB_ENTRY_W-1:0] mk_entry(input tlb_req_t r);
    return {r.vpn, r.pfn, 1'b1, r.present, r.rw, r.pcd};
  endfunction
endpackage

// File: rtl/eq_checker.sv
// eq_checker: W-bit equality comparator.
//   i_a, i_b : operands
//   o_eq     : 1 when i_a == i_b
module eq_checker #(
  parameter int W = 20
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_eq
);
  assign o_eq = (i_a == i_b);
endmodule

// File: rtl/tlb_fill_ctrl_victim_sel.sv
// tlb_victim_sel: picks the install slot -- lowest valid VPN hit, else lowest free slot, else round-robin victim.
//   i_valid      : per-entry valid bits
//   i_match      : per-entry raw VPN-compare results (qualified with valid here)
//   i_rr_ptr     : round-robin victim pointer
//   o_idx        : selected entry index
//   o_use_victim : 1 when o_idx came from i_rr_ptr (caller advances the pointer)
module tlb_victim_sel
  import cpu_defs::*;
(
  input  logic [TLB_ENTRIES-1:0] i_valid,
  input  logic [TLB_ENTRIES-1:0] i_match,
  input  logic [2:0]             i_rr_ptr,
  output logic [2:0]             o_idx,
  output logic                   o_use_victim
);
  // Loops run high-to-low so the lowest qualifying index is written last and wins;
  // the hit loop runs after the free-slot loop so a hit overrides a free slot.
  always_comb begin
    o_idx        = i_rr_ptr;
    o_use_victim = 1'b1;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--)
      if (!i_valid[i]) begin
        o_idx        = 3'(i);
        o_use_victim = 1'b0;
      end
    for (int i = TLB_ENTRIES - 1; i >= 0; i--)
      if (i_valid[i] && i_match[i]) begin
        o_idx        = 3'(i);
        o_use_victim = 1'b0;
      end
  end
endmodule

// File: rtl/tlb_fill_ctrl.sv
// tlb_fill_ctrl: sole writer of the 8-entry instruction TLB; installs entries and flushes on CR3 writes.
//   clk, rst_n            : clock, asynchronous active-low reset
//   wr_valid/wr_ready     : install handshake; wr_vpn/pfn/present/rw/pcd carry the entry
//   wr_done, wr_idx       : one-cycle completion pulse and the index written
//   flush_req, flush_busy : invalidate-all request and in-progress flag
//   TLB                   : packed entries, entry i at [27*i+26:27*i], straight from registers
// Build option TLB_INIT_EN: reset loads the array from INIT_TLB instead of zeros.
module tlb_fill_ctrl
  import cpu_defs::*;
#(
  parameter int                             N_ENTRIES = 8,
  parameter int                             ENTRY_W   = 27,
  parameter logic [N_ENTRIES*ENTRY_W-1:0]   INIT_TLB  = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [19:0]                    wr_vpn,
  input  logic [2:0]                     wr_pfn,
  input  logic                           wr_present,
  input  logic                           wr_rw,
  input  logic                           wr_pcd,
  output logic                           wr_done,
  output logic [2:0]                     wr_idx,
  input  logic                           flush_req,
  output logic                           flush_busy,
  output logic [N_ENTRIES*ENTRY_W-1:0]   TLB
);
`ifdef TLB_INIT_EN
  localparam logic [N_ENTRIES*ENTRY_W-1:0] RST_IMG = INIT_TLB;
`else
  // INIT_TLB is deliberately ignored in this build; masking keeps it referenced.
  localparam logic [N_ENTRIES*ENTRY_W-1:0] RST_IMG = INIT_TLB & {(N_ENTRIES*ENTRY_W){1'b0}};
`endif
  tlb_state_t          r_state, w_state_nxt;
  logic [ENTRY_W-1:0]  r_ent [N_ENTRIES];
  tlb_req_t            r_req;
  logic [2:0]          r_rr_ptr, r_fcnt, r_idx;
  logic                r_done, r_flush_pend;
  logic [N_ENTRIES-1:0] w_valid, w_match;
  logic [2:0]          w_sel_idx;
  logic                w_use_victim, w_flush_go, w_accept;

  for (genvar g = 0; g < N_ENTRIES; g++) begin : g_ent
    assign TLB[g*ENTRY_W +: ENTRY_W] = r_ent[g];
    assign w_valid[g] = r_ent[g][TLB_V];
    eq_checker #(.W(20)) u_eq (
      .i_a  (r_ent[g][TLB_VPN_HI:TLB_VPN_LO]),
      .i_b  (r_req.vpn),
      .o_eq (w_match[g])
    );
  end

  tlb_victim_sel u_sel (
    .i_valid      (w_valid),
    .i_match      (w_match),
    .i_rr_ptr     (r_rr_ptr),
    .o_idx        (w_sel_idx),
    .o_use_victim (w_use_victim)
  );

  // A flush latched during PROBE/WRITE blocks new installs until it has run.
  // wr_ready is gated by rst_n so it reads 0 while reset is held.
  always_comb begin
    w_flush_go  = (r_state == S_IDLE) && (flush_req || r_flush_pend);
    wr_ready    = rst_n && (r_state == S_IDLE) && !flush_req && !r_flush_pend;
    w_accept    = wr_valid && wr_ready;
    w_state_nxt = w_flush_go                             ? S_FLUSH :
                  w_accept                               ? S_PROBE :
                  (r_state == S_PROBE)                   ? S_WRITE :
                  (r_state == S_WRITE)                   ? S_IDLE  :
                  (r_state == S_FLUSH && r_fcnt == 3'd7) ? S_IDLE  : r_state;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRIES; i++) r_ent[i] <= RST_IMG[i*ENTRY_W +: ENTRY_W];
      r_req        <= '0;
      r_rr_ptr     <= '0;
      r_fcnt       <= '0;
      r_idx        <= '0;
      r_done       <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      r_done <= (r_state == S_WRITE);
      if (w_accept) r_req <= {wr_vpn, wr_pfn, wr_present, wr_rw, wr_pcd};
      if (w_flush_go) begin
        r_fcnt       <= '0;
        r_flush_pend <= 1'b0;
      end else if ((r_state == S_PROBE || r_state == S_WRITE) && flush_req)
        r_flush_pend <= 1'b1;
      if (r_state == S_PROBE) begin
        r_idx <= w_sel_idx;
        if (w_use_victim) r_rr_ptr <= r_rr_ptr + 3'd1;
      end
      if (r_state == S_WRITE) r_ent[r_idx] <= mk_entry(r_req);
      if (r_state == S_FLUSH) begin
        r_ent[r_fcnt][TLB_V] <= 1'b0;
        r_fcnt               <= r_fcnt + 3'd1;
        if (r_fcnt == 3'd7) r_rr_ptr <= '0;
      end
    end
  end

  assign wr_done    = r_done;
  assign wr_idx     = r_idx;
  assign flush_busy = (r_state == S_FLUSH);
endmodule

// File: doc/tlb_fill_ctrl.md
Name: tlb_fill_ctrl

Overview:
- Owns the 8-entry instruction TLB register array and is its only writer. Drives the packed TLB vector read combinationally by the fetch TLB lookup.
- Accepts install requests from the page-walk/OS-load path over a valid/ready handshake. Overwrites a matching VPN if present, else fills the first invalid slot, else evicts a round-robin victim.
- Provides a sequential flush (invalidate-all) for CR3 writes.

Parameters:
- N_ENTRIES, 8, number of TLB entries (fixed to 8; pointer widths are 3 bits)
- ENTRY_W, 27, bits per entry
- INIT_TLB, 216'h0, reset image used only when TLB_INIT_EN is defined

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  install request valid
- wr_ready  out  1  install request accepted when high with wr_valid
- wr_vpn  in  20  virtual page number [31:12]
- wr_pfn  in  3  physical frame number
- wr_present  in  1  page present bit
- wr_rw  in  1  writable bit
- wr_pcd  in  1  page cache disable bit
- wr_done  out  1  one-cycle pulse after the entry is written
- wr_idx  out  3  index written; valid with wr_done
- flush_req  in  1  invalidate-all request (pulse or level)
- flush_busy  out  1  high while flush is in progress
- TLB  out  216  packed entries; entry i at [27*i+26:27*i]

Behaviour:
- Entry format: [26:7] VPN, [6:4] PFN, [3] valid, [2] present, [1] rw, [0] pcd.
- Reset (async, rst_n=0): all entries 0 (invalid); rr_ptr=0; state IDLE; wr_ready=0; wr_done=0; wr_idx=0; flush_busy=0. The reset is unconditional, including mid-request or mid-flush; a pending request is dropped.
- States: IDLE, PROBE, WRITE, FLUSH.
- IDLE: wr_ready = ~flush_req.
  - If flush_req: go to FLUSH with fcnt=0. flush_req wins over a simultaneous wr_valid; the request is not accepted and stays pending.
  - Else if wr_valid: capture the request and go to PROBE.
- PROBE (1 cycle) selects the target index:
  - Lowest index with valid=1 and VPN==captured VPN.
  - Else lowest index with valid=0.
  - Else rr_ptr.
  - Latch the index and go to WRITE.
  - rr_ptr increments mod 8 (7->0) only when the victim path is taken.
- WRITE (1 cycle): at the edge, the target entry is written with {vpn,pfn,1'b1,present,rw,pcd}. Next cycle wr_done=1 with wr_idx=target; go to IDLE.
- Latency: handshake edge E0 -> entry visible on TLB after edge E2. wr_done is high in the cycle after E2. Back-to-back acceptance is possible at E3, i.e. 3 cycles per install.
- wr_ready is 0 in PROBE/WRITE/FLUSH. flush_req arriving in PROBE/WRITE is held as flush_pend and serviced on return to IDLE, before any new install.
- FLUSH: each cycle clears the valid bit of entry fcnt and increments fcnt. After entry 7, go to IDLE and set rr_ptr=0. flush_busy=1 throughout FLUSH. Duration is 8 cycles. flush_req during FLUSH is ignored.
- Other fields are untouched by flush. Only the valid bit clears.
- TLB is a direct register output with no combinational path from inputs.

Optional Feature:
- TLB_INIT_EN
  - Defined: reset loads TLB from INIT_TLB, and rr_ptr resets to 0. Used for the preloaded-page-table boot model.
  - Undefined: reset clears all entries to 0, and INIT_TLB is unused.

Decomposition:
- Shared package/include cpu_defs:
  - TLB_ENTRIES=8, TLB_ENTRY_W=27.
  - Field offsets TLB_VPN_HI=26, TLB_VPN_LO=7, TLB_PFN_HI=6, TLB_PFN_LO=4, TLB_V=3, TLB_P=2, TLB_RW=1, TLB_PCD=0.
  - State encodings.
- One sub-module: tlb_victim_sel. It is combinational: 8 valid bits, 8 VPN-match bits and rr_ptr in; 3-bit index and use_victim flag out. It reuses the existing eq_checker for the VPN compares.

Test Plan:
- Reset, then install vpn=20'h00401, pfn=3, present=1 -> wr_done 3 cycles after handshake, wr_idx=0, TLB[26:0]={20'h00401,3'd3,1,1,0,0}.
- Install 8 distinct VPNs, then a 9th vpn=20'h12345 -> wr_idx=0 (rr_ptr=0). A 10th distinct VPN -> wr_idx=1.
- Re-install an existing vpn=20'h00401 with pfn=5 -> same index overwritten, pfn=5, rr_ptr unchanged, no duplicate entry.
- flush_req while wr_valid high in IDLE -> wr_ready=0, flush_busy for 8 cycles, all valid bits 0. The pending install then completes with wr_idx=0.
- rst_n low during WRITE -> TLB all zero (or INIT_TLB with TLB_INIT_EN), no wr_done pulse, wr_ready=0 until release.
